// File: rtl/nexys_starship_spawn_prng_if.sv
// Control/result bundle between the game-state FSM (master) and the spawn PRNG (slave).
// The master drives enable, seeding, difficulty and exclusivity; the slave returns the spawn pulses and the channel-0 noise word.
interface nexys_starship_spawn_prng_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 16
);
    logic             en;
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] threshold;
    logic             exclusive;
    logic [N_CH-1:0]  spawn;
    logic [WIDTH-1:0] lfsr0;

    modport master (
        output en, seed_load, seed, threshold, exclusive,
        input  spawn, lfsr0
    );

    modport slave (
        input  en, seed_load, seed, threshold, exclusive,
        output spawn, lfsr0
    );
endinterface

// File: rtl/nexys_starship_spawn_prng.sv
// Multi-channel spawn generator: one Galois LFSR per channel compared against a run-time threshold,
// with a per-channel cooldown and an optional lowest-index-wins exclusive mode.
module nexys_starship_spawn_prng #(
    parameter int               N_CH         = 4,
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h0001,
    parameter int               COOLDOWN     = 3,
    parameter logic [WIDTH-1:0] SALT         = 16'h9E37
) (
    input logic                          Clk,
    input logic                          Reset,
    nexys_starship_spawn_prng_if.slave   bus
);

    localparam int              CD_W    = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

    logic [WIDTH-1:0] r_state [N_CH];
    logic [CD_W-1:0]  r_cd    [N_CH];
    logic [N_CH-1:0]  r_spawn;
    logic [N_CH-1:0]  w_hit;
    logic [N_CH-1:0]  w_grant;

    // Channel seeds are decorrelated by XOR with a multiple of SALT; an all-zero seed would lock the LFSR.
    function automatic logic [WIDTH-1:0] seed_for(input logic [WIDTH-1:0] s, input int ch);
        logic [63:0]      prod;
        logic [WIDTH-1:0] v;
        prod = 64'(ch) * 64'(SALT);
        v    = s ^ prod[WIDTH-1:0];
        return (v == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : v;
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // Hit detection on the current registered state of each channel.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_hit[i] = bus.en & (r_cd[i] == '0) & (r_state[i] < bus.threshold);
        end
    end

    // Exclusive mode keeps only the lowest set bit (two's-complement isolate).
    always_comb begin
        w_grant = w_hit;
        if (bus.exclusive) begin
            w_grant = w_hit & (~w_hit + N_CH'(1));
        end else begin
            w_grant = w_hit;
        end
    end

    // State, cooldown and spawn registers; reset beats reload beats stepping.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= seed_for(DEFAULT_SEED, i);
                r_cd[i]    <= '0;
            end
            r_spawn <= '0;
        end else if (bus.seed_load) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= seed_for(bus.seed, i);
                r_cd[i]    <= '0;
            end
            r_spawn <= '0;
        end else begin
            r_spawn <= w_grant;
            for (int i = 0; i < N_CH; i++) begin
                if (w_grant[i]) begin
                    r_cd[i] <= CD_LOAD;
                end else if (bus.en && (r_cd[i] != '0)) begin
                    r_cd[i] <= r_cd[i] - CD_W'(1);
                end else begin
                    r_cd[i] <= r_cd[i];
                end
                if (bus.en) begin
                    r_state[i] <= lfsr_step(r_state[i]);
                end else begin
                    r_state[i] <= r_state[i];
                end
            end
        end
    end

    assign bus.spawn = r_spawn;
    assign bus.lfsr0 = r_state[0];

endmodule

// File: tb/tb_nexys_starship_spawn_prng.sv
// Self-checking bench for the spawn PRNG: directed scenarios plus randomized traffic against a behavioural model,
// and a second cooldown-free instance that sweeps one full LFSR period.
module tb_nexys_starship_spawn_prng;

    localparam int          N_CH  = 4;
    localparam int unsigned TAPS  = 32'hB400;
    localparam int unsigned DEF   = 32'h0001;
    localparam int unsigned SALT  = 32'h9E37;
    localparam int          CD    = 3;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done2 = 1'b0;

    int unsigned m_st [N_CH];
    int          m_cd [N_CH];
    logic [3:0]  m_spawn;

    always #5 clk = ~clk;

    nexys_starship_spawn_prng_if #(.N_CH(4), .WIDTH(16)) u_if ();
    nexys_starship_spawn_prng_if #(.N_CH(4), .WIDTH(16)) u_if2 ();

    nexys_starship_spawn_prng #(.N_CH(4), .WIDTH(16), .COOLDOWN(3)) u_dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (u_if.slave)
    );

    nexys_starship_spawn_prng #(.N_CH(4), .WIDTH(16), .COOLDOWN(0)) u_dut2 (
        .Clk   (clk),
        .Reset (rst2),
        .bus   (u_if2.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned mseed(input int unsigned s, input int ch);
        int unsigned v;
        v = (s ^ ((ch * SALT) % 65536)) & 32'hFFFF;
        return (v == 0) ? 32'd1 : v;
    endfunction

    // Reference: what the block must do on one rising edge, from the current inputs.
    task automatic model_edge();
        int winners[$];
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin m_st[i] = mseed(DEF, i); m_cd[i] = 0; end
            m_spawn = 4'b0000;
        end else if (u_if.seed_load) begin
            for (int i = 0; i < N_CH; i++) begin m_st[i] = mseed(32'(u_if.seed), i); m_cd[i] = 0; end
            m_spawn = 4'b0000;
        end else begin
            for (int i = 0; i < N_CH; i++)
                if (u_if.en && m_cd[i] == 0 && m_st[i] < 32'(u_if.threshold)) winners.push_back(i);
            if (u_if.exclusive) while (winners.size() > 1) void'(winners.pop_back());
            m_spawn = 4'b0000;
            foreach (winners[k]) m_spawn[winners[k]] = 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (m_spawn[i]) m_cd[i] = CD;
                else if (u_if.en && m_cd[i] > 0) m_cd[i] = m_cd[i] - 1;
                if (u_if.en) m_st[i] = (m_st[i] / 2) ^ (((m_st[i] % 2) == 1) ? TAPS : 32'd0);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_val("spawn", 32'(u_if.spawn), 32'(m_spawn));
        check_val("lfsr0", 32'(u_if.lfsr0), m_st[0]);
    endtask

    task automatic set_in(input logic r, input logic sl, input logic [15:0] sd,
                          input logic e, input logic [15:0] th, input logic ex);
        rst = r; u_if.seed_load = sl; u_if.seed = sd;
        u_if.en = e; u_if.threshold = th; u_if.exclusive = ex;
    endtask

    // Cooldown-free instance: one full period at threshold 4000 must hit exactly 3FFF times.
    initial begin
        int hits;
        hits = 0;
        rst2 = 1'b1;
        u_if2.en = 1'b0; u_if2.seed_load = 1'b0; u_if2.seed = 16'h0000;
        u_if2.threshold = 16'h4000; u_if2.exclusive = 1'b0;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        u_if2.en = 1'b1;
        for (int k = 0; k < 65535; k++) begin
            @(posedge clk);
            #1;
            if (u_if2.spawn[0]) hits++;
        end
        check_val("period_hits_ch0", 32'(hits), 32'd16383);
        check_val("period_wrap_lfsr0", 32'(u_if2.lfsr0), 32'h0001);
        done2 = 1'b1;
    end

    initial begin
        logic [15:0] lfsr_first [4];
        logic [15:0] saved;
        int          sp_seen;
        lfsr_first[0] = 16'hB400; lfsr_first[1] = 16'h5A00;
        lfsr_first[2] = 16'h2D00; lfsr_first[3] = 16'h1680;

        // Reset, then threshold 0: no spawns and the documented lfsr0 sequence.
        set_in(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        tick();
        check_val("rst_spawn", 32'(u_if.spawn), 32'h0);
        check_val("rst_lfsr0", 32'(u_if.lfsr0), 32'h0001);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);
        sp_seen = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (k < 4) check_val("seq_lfsr0", 32'(u_if.lfsr0), 32'(lfsr_first[k]));
            if (u_if.spawn != 4'b0000) sp_seen++;
        end
        check_val("thr0_no_spawn", 32'(sp_seen), 32'd0);

        // Full threshold, non-exclusive: all channels aligned with period 4.
        set_in(1'b1, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
        tick();
        u_if.en = 1'b1; rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_val("full_all", 32'(u_if.spawn), (k % 4 == 0) ? 32'hF : 32'h0);
        end

        // Full threshold, exclusive: rotating one-hot.
        set_in(1'b1, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1);
        tick();
        u_if.en = 1'b1; rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_val("excl_rot", 32'(u_if.spawn), 32'(1 << (k % 4)));
        end

        // Pause: frozen while en=0, then resumes.
        set_in(1'b1, 1'b0, 16'h0000, 1'b0, 16'h2000, 1'b0);
        tick();
        u_if.en = 1'b1; rst = 1'b0;
        repeat (6) tick();
        saved = u_if.lfsr0;
        u_if.en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val("pause_lfsr0", 32'(u_if.lfsr0), 32'(saved));
            check_val("pause_spawn", 32'(u_if.spawn), 32'h0);
        end
        u_if.en = 1'b1;
        repeat (6) tick();

        // seed_load with seed 0 mid-cooldown: zero substitution and cooldowns cleared.
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0);
        repeat (2) tick();
        set_in(1'b0, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b0);
        tick();
        check_val("load_lfsr0", 32'(u_if.lfsr0), 32'h0001);
        check_val("load_spawn", 32'(u_if.spawn), 32'h0);
        u_if.seed_load = 1'b0;
        tick();
        check_val("load_respawn", 32'(u_if.spawn), 32'hF);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(199) == 0);
            u_if.seed_load = ($urandom_range(49) == 0);
            u_if.seed = 16'($urandom);
            u_if.en = ($urandom_range(9) < 8);
            case ($urandom_range(3))
                0: u_if.threshold = 16'h0000;
                1: u_if.threshold = 16'hFFFF;
                default: u_if.threshold = 16'($urandom);
            endcase
            u_if.exclusive = 1'($urandom);
            tick();
        end

        for (int k = 0; k < 100000 && !done2; k++) @(posedge clk);
        if (!done2) check_val("period_timeout", 32'h0, 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
